// File: rtl/uart_mem_dump_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_mem_dump_tx                                              |
// | Function : reads a range of memory words, sends them as 8N1 UART bytes   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_mem_dump_tx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int ADDR_W       = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_adr,
   input  logic [31:0]       rd_data,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int c_BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] c_BIT_START = 4'd0;
   localparam logic [3:0] c_BIT_STOP  = 4'd9;
   localparam logic [1:0] c_BYTE_LAST = 2'd3;

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_READ = 3'd1;
   localparam logic [2:0] c_WAIT = 3'd2;
   localparam logic [2:0] c_SEND = 3'd3;
   localparam logic [2:0] c_DONE = 3'd4;

   logic [2:0]          r_state;
   logic [2:0]          w_next_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_count;
   logic [31:0]         r_word;
   logic [c_BAUD_W-1:0] r_baud;
   logic [3:0]          r_bit;
   logic [1:0]          r_byte;

   logic w_accept;
   logic w_empty_req;
   logic w_baud_end;
   logic w_byte_end;
   logic w_word_end;
   logic w_last_word;

   assign w_accept    = (r_state == c_IDLE) && start;
   assign w_empty_req = (word_count == '0);
   assign w_baud_end  = (r_state == c_SEND) && (r_baud == c_BAUD_LAST);
   assign w_byte_end  = w_baud_end && (r_bit == c_BIT_STOP);
   assign w_word_end  = w_byte_end && (r_byte == c_BYTE_LAST);
   assign w_last_word = (r_count == (ADDR_W+1)'(1));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_next_state = w_empty_req ? c_DONE : c_READ;
            end
         end
         c_READ: w_next_state = c_WAIT;
         c_WAIT: w_next_state = c_SEND;
         c_SEND: begin
            if (w_word_end) begin
               w_next_state = w_last_word ? c_DONE : c_READ;
            end
         end
         c_DONE:  w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   // Output logic; tx depends only on state so an async reset idles the line at once
   always_comb begin
      tx    = 1'b1;
      busy  = 1'b0;
      done  = 1'b0;
      rd_en = 1'b0;
      case (r_state)
         c_READ: begin
            busy  = 1'b1;
            rd_en = 1'b1;
         end
         c_WAIT: busy = 1'b1;
         c_SEND: begin
            busy = 1'b1;
            if (r_bit == c_BIT_START) begin
               tx = 1'b0;
            end else if (r_bit == c_BIT_STOP) begin
               tx = 1'b1;
            end else begin
               tx = r_word[0];
            end
         end
         c_DONE:  done = 1'b1;
         default: tx = 1'b1;
      endcase
   end

   assign rd_adr = r_addr;

   // Address and remaining-word bookkeeping; address only advances when another read follows
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr  <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         r_addr  <= base_addr;
         r_count <= word_count;
      end else if (w_word_end) begin
         r_count <= r_count - (ADDR_W+1)'(1);
         if (!w_last_word) begin
            r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

   // Serialiser: the word register shifts right once per data bit, giving LSB-first little-endian order
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_word <= '0;
         r_baud <= '0;
         r_bit  <= '0;
         r_byte <= '0;
      end else if (r_state == c_WAIT) begin
         r_word <= rd_data;
         r_baud <= '0;
         r_bit  <= '0;
         r_byte <= '0;
      end else if (r_state == c_SEND) begin
         if (w_baud_end) begin
            r_baud <= '0;
            if ((r_bit != c_BIT_START) && (r_bit != c_BIT_STOP)) begin
               r_word <= {1'b0, r_word[31:1]};
            end
            if (w_byte_end) begin
               r_bit  <= '0;
               r_byte <= r_byte + 2'd1;
            end else begin
               r_bit <= r_bit + 4'd1;
            end
         end else begin
            r_baud <= r_baud + c_BAUD_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_dump_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_mem_dump_tx                                           |
// | Function : directed self-checking bench for uart_mem_dump_tx             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_mem_dump_tx;

   localparam int CPB = 4;
   localparam int AW  = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   word_count = '0;
   logic          rd_en;
   logic [AW-1:0] rd_adr;
   logic [31:0]   rd_data = '0;
   logic          tx;
   logic          busy;
   logic          done;

   int vectors = 0;
   int errors  = 0;
   int done_cnt = 0;

   uart_mem_dump_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .word_count(word_count), .rd_en(rd_en), .rd_adr(rd_adr),
      .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      case (a)
         14'h0010: return 32'h11223344;
         14'h0020: return 32'hCAFEF00D;
         14'h3FFE: return 32'hA1B2C3D4;
         14'h3FFF: return 32'h55AA00FF;
         14'h0000: return 32'hDEADBEEF;
         default:  return 32'h0BADF00D;
      endcase
   endfunction

   // Synchronous BRAM model: data valid the cycle after rd_en
   always @(posedge clk) if (rd_en) rd_data <= mem_word(rd_adr);
   always @(negedge clk) if (done) done_cnt = done_cnt + 1;

   task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] n);
      @(negedge clk);
      base_addr = a; word_count = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered at the first start-bit cycle; leaves at the cycle after the word.
   // inj >= 0 pulses a disruptive start request at that cycle offset.
   task automatic recv_word(input logic [31:0] exp, input string tag, input int inj);
      logic [9:0] frame;
      logic       first;
      logic       stable;
      logic       busy_ok;
      int         k;
      k = 0;
      busy_ok = 1'b1;
      for (int by = 0; by < 4; by++) begin
         frame = {1'b1, exp[8*by +: 8], 1'b0};
         for (int b = 0; b < 10; b++) begin
            first  = tx;
            stable = 1'b1;
            for (int c = 0; c < CPB; c++) begin
               if (tx !== first) stable = 1'b0;
               if (busy !== 1'b1) busy_ok = 1'b0;
               if (inj >= 0 && k == inj) begin
                  start = 1'b1; base_addr = 14'h1234; word_count = 15'd7;
               end else begin
                  start = 1'b0;
               end
               k++;
               @(negedge clk);
            end
            vectors++;
            if (!stable || first !== frame[b]) begin
               errors++;
               $display("FAIL %s byte%0d bit%0d: tx=%b stable=%b, required %b",
                        tag, by, b, first, stable, frame[b]);
            end
         end
      end
      vectors++;
      if (!busy_ok) begin
         errors++;
         $display("FAIL %s busy during frame: dropped, required 1", tag);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      vectors++;
      if (rd_adr !== 14'h0) begin
         errors++; $display("FAIL reset rd_adr: %h, required 0000", rd_adr);
      end
      for (int i = 0; i < 100; i++) begin
         vectors++;
         if ({tx, busy, done, rd_en} !== 4'b1000) begin
            errors++;
            $display("FAIL reset idle cyc%0d: tx/busy/done/rd_en=%b, required 1000", i,
                     {tx, busy, done, rd_en});
         end
         @(negedge clk);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL async reset idle: tx=%b busy=%b, required 1 0", tx, busy);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_word();
      done_cnt = 0;
      do_start(14'h0010, 15'd1);
      vectors++;
      if (rd_en !== 1'b1 || rd_adr !== 14'h0010 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single T+1: rd_en=%b rd_adr=%h busy=%b, required 1 0010 1",
                  rd_en, rd_adr, busy);
      end
      @(negedge clk);
      vectors++;
      if (rd_en !== 1'b0 || tx !== 1'b1) begin
         errors++; $display("FAIL single T+2: rd_en=%b tx=%b, required 0 1", rd_en, tx);
      end
      @(negedge clk);
      recv_word(32'h11223344, "single", -1);
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single done T+163: done=%b busy=%b tx=%b, required 1 0 1", done, busy, tx);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || done_cnt != 1) begin
         errors++;
         $display("FAIL single done width: done=%b count=%0d, required 0 1", done, done_cnt);
      end
   endtask

   task automatic test_wrap_three();
      logic [AW-1:0] adr [3];
      adr[0] = 14'h3FFE; adr[1] = 14'h3FFF; adr[2] = 14'h0000;
      do_start(14'h3FFE, 15'd3);
      for (int w = 0; w < 3; w++) begin
         vectors++;
         if (rd_en !== 1'b1 || rd_adr !== adr[w] || tx !== 1'b1) begin
            errors++;
            $display("FAIL wrap read%0d: rd_en=%b rd_adr=%h tx=%b, required 1 %h 1",
                     w, rd_en, rd_adr, tx, adr[w]);
         end
         @(negedge clk);
         vectors++;
         if (rd_en !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL wrap gap%0d: rd_en=%b tx=%b, required 0 1", w, rd_en, tx);
         end
         @(negedge clk);
         recv_word(mem_word(adr[w]), "wrap", -1);
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || rd_adr !== 14'h0000) begin
         errors++;
         $display("FAIL wrap done: done=%b busy=%b rd_adr=%h, required 1 0 0000", done, busy, rd_adr);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_count();
      logic seen_busy;
      logic seen_rd;
      do_start(14'h0123, 15'd0);
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL zero T+1: done=%b busy=%b rd_en=%b tx=%b, required 1 0 0 1",
                  done, busy, rd_en, tx);
      end
      seen_busy = 1'b0; seen_rd = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy || rd_en || !tx || done) seen_busy = 1'b1;
         if (rd_en) seen_rd = 1'b1;
      end
      vectors++;
      if (seen_busy || seen_rd) begin
         errors++;
         $display("FAIL zero after: activity=%b rd=%b, required 0 0", seen_busy, seen_rd);
      end
   endtask

   task automatic test_start_while_busy();
      done_cnt = 0;
      do_start(14'h0020, 15'd2);
      vectors++;
      if (rd_adr !== 14'h0020) begin
         errors++; $display("FAIL busy read0: rd_adr=%h, required 0020", rd_adr);
      end
      @(negedge clk);
      @(negedge clk);
      recv_word(32'hCAFEF00D, "busy_w0", 50);
      vectors++;
      if (rd_en !== 1'b1 || rd_adr !== 14'h0021) begin
         errors++;
         $display("FAIL busy read1: rd_en=%b rd_adr=%h, required 1 0021", rd_en, rd_adr);
      end
      @(negedge clk);
      @(negedge clk);
      recv_word(32'h0BADF00D, "busy_w1", -1);
      vectors++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL busy done: done=%b, required 1", done);
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy done pulses: count=%0d busy=%b, required 1 0", done_cnt, busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_start(14'h0030, 15'd1);
      @(negedge clk);
      @(negedge clk);
      // byte 2 of 0x0BADF00D is 0xAD, its bit 5 (data bit 4) is 0
      repeat ((20 + 5) * CPB + 1) @(negedge clk);
      vectors++;
      if (tx !== 1'b0) begin
         errors++; $display("FAIL midreset pre: tx=%b, required 0", tx);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || rd_adr !== 14'h0) begin
         errors++;
         $display("FAIL midreset async: tx=%b busy=%b rd_en=%b rd_adr=%h, required 1 0 0 0000",
                  tx, busy, rd_en, rd_adr);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      do_start(14'h3FFF, 15'd1);
      vectors++;
      if (rd_en !== 1'b1 || rd_adr !== 14'h3FFF) begin
         errors++;
         $display("FAIL midreset restart: rd_en=%b rd_adr=%h, required 1 3fff", rd_en, rd_adr);
      end
      @(negedge clk);
      @(negedge clk);
      recv_word(32'h55AA00FF, "restart", -1);
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL restart done: done=%b busy=%b, required 1 0", done, busy);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_wrap_three();
      test_zero_count();
      test_start_while_busy();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
